lu_scoreboard: RTL and testbench

- Parametrised scoreboard-based hazard unit for long-latency writers (multiply/divide, CP2/GTE).
- Sits beside the ID-stage hazard/forward logic. The single-cycle pipeline keeps its Want/Need forwarding; this block tracks registers still owed by multi-cycle units.
- Stalls dependent issue (RAW, WAW, structural) and flags the writeback-bus bypass.
- Generalises the single-bit "CP2 busy" stall to per-register tracking, with N source ports and latency prediction.

---
 rtl/lu_scoreboard.sv | 137 +++++++++++++
 tb/tb_lu_scoreboard.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lu_scoreboard.sv
// lu_scoreboard
// Per-register scoreboard for long-latency writers (mul/div, CP2/GTE).
// Each tracked register owes a result from a multi-cycle unit and carries a
// free-running countdown of its predicted latency. Dependent issue is held
// for RAW, WAW and "too many outstanding" hazards; a result arriving on the
// lu writeback bus in the same cycle releases the hazard and is bypassed.
//
// Ports
//   clock           system clock, rising edge
//   reset           synchronous, active-low
//   issue_valid     ID-stage instruction requests issue
//   issue_src       NUM_SRC packed source indices, src i at [i*ADDR_W +: ADDR_W]
//   issue_src_need  src i is actually read
//   issue_dst       destination register
//   issue_dst_we    instruction writes issue_dst
//   issue_lat       predicted cycles to writeback, 0 = single-cycle op
//   ext_stall       stall from the rest of the pipeline
//   lu_wb_valid     long-latency unit writes back this cycle
//   lu_wb_reg       register written by that result
//   sb_stall        issue must hold (combinational)
//   src_fwd         src i takes the lu writeback bus (combinational)
//   outstanding     number of busy registers (registered)
//   sb_error        sticky: writeback to a register that was not busy, or r0
//   sb_overdue      sticky: a busy register's countdown expired unserved
module lu_scoreboard #(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int LAT_W   = 5,
    parameter int MAX_OUT = 4,
    localparam int OUT_W  = $clog2(MAX_OUT + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] issue_src,
    input  logic [NUM_SRC-1:0]        issue_src_need,
    input  logic [ADDR_W-1:0]         issue_dst,
    input  logic                      issue_dst_we,
    input  logic [LAT_W-1:0]          issue_lat,
    input  logic                      ext_stall,
    input  logic                      lu_wb_valid,
    input  logic [ADDR_W-1:0]         lu_wb_reg,
    output logic                      sb_stall,
    output logic [NUM_SRC-1:0]        src_fwd,
    output logic [OUT_W-1:0]          outstanding,
    output logic                      sb_error,
    output logic                      sb_overdue
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [OUT_W-1:0] MAX_OUT_V = OUT_W'(MAX_OUT);

    // busy[0] is held at 0 so r0 lookups never report a hazard.
    logic [NREG-1:0]  busy;
    logic [LAT_W-1:0] cnt [NREG];

    logic              wb_hit_any;
    logic              long_issue;
    logic              raw_any;
    logic              waw;
    logic              structural;
    logic              issue_fire;
    logic              long_fire;
    logic              overdue_now;
    logic [ADDR_W-1:0] src_idx;
    logic              src_hit;

    assign wb_hit_any = lu_wb_valid & busy[lu_wb_reg] & (lu_wb_reg != '0);
    assign long_issue = issue_dst_we & (issue_lat != '0) & (issue_dst != '0);

    always_comb begin
        raw_any = 1'b0;
        src_fwd = '0;
        src_idx = '0;
        src_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_idx    = issue_src[i*ADDR_W +: ADDR_W];
            src_hit    = wb_hit_any & (lu_wb_reg == src_idx);
            raw_any    = raw_any | (issue_src_need[i] & busy[src_idx] & ~src_hit);
            src_fwd[i] = issue_src_need[i] & src_hit & (src_idx != '0);
        end
    end

    assign waw = issue_dst_we & (issue_dst != '0) & busy[issue_dst]
               & ~(wb_hit_any & (lu_wb_reg == issue_dst));
    // A retirement anywhere this cycle frees a slot for the new long op.
    assign structural = long_issue & (outstanding == MAX_OUT_V) & ~wb_hit_any;

    assign sb_stall   = issue_valid & (raw_any | waw | structural);
    assign issue_fire = issue_valid & ~sb_stall & ~ext_stall;
    assign long_fire  = issue_fire & long_issue;

    // A register being cleared or re-armed this cycle is not counted as overdue.
    always_comb begin
        overdue_now = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if (busy[r] && cnt[r] == '0
                && !(wb_hit_any && lu_wb_reg == ADDR_W'(r))
                && !(long_fire && issue_dst == ADDR_W'(r)))
                overdue_now = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            busy        <= '0;
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
            outstanding <= '0;
            sb_error    <= 1'b0;
            sb_overdue  <= 1'b0;
        end else begin
            busy[0] <= 1'b0;
            cnt[0]  <= '0;
            for (int r = 1; r < NREG; r++) begin
                if (long_fire && issue_dst == ADDR_W'(r)) begin
                    busy[r] <= 1'b1;
                    cnt[r]  <= issue_lat;
                end else if (wb_hit_any && lu_wb_reg == ADDR_W'(r)) begin
                    busy[r] <= 1'b0;
                    cnt[r]  <= '0;
                end else if (busy[r] && cnt[r] != '0) begin
                    cnt[r]  <= cnt[r] - LAT_W'(1);
                end
            end

            case ({long_fire, wb_hit_any})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase

            if (lu_wb_valid && !wb_hit_any) sb_error <= 1'b1;
            if (overdue_now) sb_overdue <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lu_scoreboard.sv
module tb_lu_scoreboard;

    logic       clock = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic [9:0] issue_src;
    logic [1:0] issue_src_need;
    logic [4:0] issue_dst;
    logic       issue_dst_we;
    logic [4:0] issue_lat;
    logic       ext_stall;
    logic       lu_wb_valid;
    logic [4:0] lu_wb_reg;
    logic       sb_stall;
    logic [1:0] src_fwd;
    logic [2:0] outstanding;
    logic       sb_error;
    logic       sb_overdue;

    lu_scoreboard dut (
        .clock          (clock),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_src      (issue_src),
        .issue_src_need (issue_src_need),
        .issue_dst      (issue_dst),
        .issue_dst_we   (issue_dst_we),
        .issue_lat      (issue_lat),
        .ext_stall      (ext_stall),
        .lu_wb_valid    (lu_wb_valid),
        .lu_wb_reg      (lu_wb_reg),
        .sb_stall       (sb_stall),
        .src_fwd        (src_fwd),
        .outstanding    (outstanding),
        .sb_error       (sb_error),
        .sb_overdue     (sb_overdue)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit       stall;
        bit [1:0] fwd;
        int       outs;
        bit       err;
        bit       ovr;
    } exp_t;

    exp_t exq[$];
    int total = 0;
    int bad   = 0;

    // Reference model: a register is "owed" with a due edge; anything still
    // owed strictly after its due edge is overdue.
    bit mb   [32];
    int mdue [32];
    bit merr;
    bit movr;
    int edge_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (exq.size() > 0) begin
            exp_t e;
            e = exq.pop_front();
            chk("sb_stall",    32'(sb_stall),    32'(e.stall));
            chk("src_fwd",     32'(src_fwd),     32'(e.fwd));
            chk("outstanding", 32'(outstanding), e.outs);
            chk("sb_error",    32'(sb_error),    32'(e.err));
            chk("sb_overdue",  32'(sb_overdue),  32'(e.ovr));
        end
    end

    function automatic int busy_count();
        int n = 0;
        for (int r = 1; r < 32; r++) if (mb[r]) n++;
        return n;
    endfunction

    task automatic model_step();
        exp_t e;
        bit hit_any, raw, waw, strl, lng, fire;
        int s [2];
        int wr, dst;
        wr  = int'(lu_wb_reg);
        dst = int'(issue_dst);
        s[0] = int'(issue_src[4:0]);
        s[1] = int'(issue_src[9:5]);
        hit_any = lu_wb_valid && wr != 0 && mb[wr];
        raw = 0;
        e.fwd = 2'b00;
        for (int i = 0; i < 2; i++) begin
            bit h;
            h = hit_any && (wr == s[i]);
            if (issue_src_need[i] && mb[s[i]] && !h) raw = 1;
            e.fwd[i] = issue_src_need[i] && h && s[i] != 0;
        end
        waw  = issue_dst_we && dst != 0 && mb[dst] && !(hit_any && wr == dst);
        lng  = issue_dst_we && issue_lat != 0 && dst != 0;
        strl = lng && busy_count() == 4 && !hit_any;
        e.stall = issue_valid && (raw || waw || strl);
        fire    = issue_valid && !e.stall && !ext_stall;
        e.outs  = busy_count();
        e.err   = merr;
        e.ovr   = movr;
        exq.push_back(e);

        if (!reset) begin
            for (int r = 0; r < 32; r++) begin mb[r] = 0; mdue[r] = 0; end
            merr = 0;
            movr = 0;
        end else begin
            for (int r = 1; r < 32; r++)
                if (mb[r] && edge_n > mdue[r] && !(hit_any && wr == r) && !(fire && lng && dst == r))
                    movr = 1;
            if (lu_wb_valid && !hit_any) merr = 1;
            if (hit_any) mb[wr] = 0;
            if (fire && lng) begin
                mb[dst]   = 1;
                mdue[dst] = edge_n + int'(issue_lat);
            end
        end
        edge_n++;
    endtask

    task automatic cyc(input bit v, input int s0, input int s1, input bit [1:0] nd,
                       input int dst, input bit we, input int lat, input bit ext,
                       input bit wbv, input int wbr, input bit rst = 1'b1);
        @(posedge clock);
        #1;
        reset          = rst;
        issue_valid    = v;
        issue_src      = {s1[4:0], s0[4:0]};
        issue_src_need = nd;
        issue_dst      = dst[4:0];
        issue_dst_we   = we;
        issue_lat      = lat[4:0];
        ext_stall      = ext;
        lu_wb_valid    = wbv;
        lu_wb_reg      = wbr[4:0];
        model_step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin mb[r] = 0; mdue[r] = 0; end
        merr = 0; movr = 0;
        reset = 0; issue_valid = 0; issue_src = '0; issue_src_need = '0;
        issue_dst = '0; issue_dst_we = 0; issue_lat = '0; ext_stall = 0;
        lu_wb_valid = 0; lu_wb_reg = '0;
        repeat (2) @(posedge clock);

        // reset held while a long op is presented
        cyc(1, 0, 0, 2'b00, 5, 1, 4, 0, 0, 0, 1'b0);
        cyc(1, 0, 0, 2'b00, 5, 1, 4, 0, 0, 0, 1'b0);
        cyc(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        idle(1);

        // RAW with same-cycle bypass
        cyc(1, 0, 0, 2'b00, 8, 1, 3, 0, 0, 0);
        cyc(1, 8, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        cyc(1, 8, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        cyc(1, 8, 0, 2'b01, 0, 0, 0, 0, 1, 8);
        cyc(1, 8, 8, 2'b11, 0, 0, 0, 0, 0, 0);
        do_reset();

        // WAW with simultaneous set/clear on r3
        cyc(1, 0, 0, 2'b00, 3, 1, 6, 0, 0, 0);
        cyc(1, 0, 0, 2'b00, 3, 1, 9, 0, 0, 0);
        cyc(1, 0, 0, 2'b00, 3, 1, 2, 0, 1, 3);
        cyc(1, 0, 3, 2'b10, 0, 0, 0, 0, 0, 0);
        idle(1);
        cyc(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 3);
        do_reset();

        // structural limit
        for (int r = 1; r <= 4; r++) cyc(1, 0, 0, 2'b00, r, 1, 20, 0, 0, 0);
        cyc(1, 0, 0, 2'b00, 6, 1, 20, 0, 0, 0);
        cyc(1, 0, 0, 2'b00, 6, 1, 20, 0, 1, 2);
        cyc(1, 0, 0, 2'b00, 7, 1, 20, 0, 0, 0);
        idle(1);
        do_reset();

        // overdue then error, both sticky
        cyc(1, 0, 0, 2'b00, 9, 1, 2, 0, 0, 0);
        idle(4);
        cyc(1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 10);
        idle(2);
        cyc(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 9);
        idle(2);
        do_reset();
        idle(1);

        // r0 and ext_stall
        cyc(1, 0, 0, 2'b00, 0, 1, 5, 0, 0, 0);
        cyc(1, 0, 0, 2'b01, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 2'b00, 7, 1, 5, 1, 0, 0);
        cyc(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        do_reset();
        cyc(1, 0, 0, 2'b00, 11, 1, 2, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(1, 11, 0, 2'b01, 0, 0, 0, 1, 0, 0);
        do_reset();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            int busyq[$];
            int wbr, lat;
            bit wbv;
            for (int r = 1; r < 32; r++) if (mb[r]) busyq.push_back(r);
            wbv = ($urandom_range(0, 99) < 35);
            if (busyq.size() > 0 && $urandom_range(0, 99) < 85)
                wbr = busyq[$urandom_range(0, busyq.size() - 1)];
            else
                wbr = $urandom_range(0, 15);
            lat = ($urandom_range(0, 9) < 3) ? 0 : $urandom_range(1, 7);
            cyc($urandom_range(0, 99) < 80, $urandom_range(0, 15), $urandom_range(0, 15),
                2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(0, 1),
                lat, $urandom_range(0, 99) < 20, wbv, wbr,
                $urandom_range(0, 99) >= 2);
        end

        idle(2);
        @(negedge clock);
        #1;
        chk("queue_drained", 32'(exq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
